cr16_mmio_responder: RTL
========================

Name: cr16_mmio_responder

Overview:
- Memory-mapped I/O responder on the CR16 processor data bus. Acts as the target end of the processor's load/store request/acknowledge handshake.
- Decodes an 8-word address window and serves loads and stores with a programmable number of wait states.
- Contains the registers for a compare/match timer with interrupt, an LED output latch and a synchronised switch input.

Parameters:
- BASE_ADDR, 16'hFF00: base of the 8-word window; decode compares addr[15:3] with BASE_ADDR[15:3].
- WAIT_STATES, 2: extra cycles inserted between request capture and ack (0..15).
- LED_W, 8: width of the LED output and switch input.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset (asserted when 0).
- req  input  1  processor access request; held until ack is seen.
- we  input  1  1 = store, 0 = load; sampled with req.
- addr  input  16  word address.
- wdata  input  16  store data.
- rdata  output  16  load data; valid only while ack = 1, otherwise 0.
- ack  output  1  one-cycle completion strobe.
- err  output  1  pulses with ack when addr is outside the window.
- irq  output  1  level interrupt: timer flag AND CTRL.ie.
- leds  output  LED_W  LED register contents.
- sw  input  LED_W  asynchronous switch inputs.

Behaviour:
- Reset (Reset = 0, asynchronous):
  - FSM goes to IDLE; ack, err, rdata, irq and leds are 0.
  - CTRL, TCOUNT, TCMP and the flag are 0; the switch synchroniser clears.
  - Reset mid-transaction abandons the access and produces no ack.
- Register map (word offset = addr[2:0]):
  - 0 CTRL: bit0 en, bit1 auto-reload, bit2 ie.
  - 1 STATUS: bit0 flag. Reads return the flag. Writing 1 to bit0 clears it (W1C).
  - 2 TCOUNT: read/write.
  - 3 TCMP: read/write.
  - 4 LEDS: read/write, low LED_W bits.
  - 5 SW: read-only, zero-extended; writes are ignored.
  - 6, 7: read as 0; writes are ignored; err = 0.
- FSM IDLE / WAIT / ACK:
  - IDLE: when req = 1, capture addr, we and wdata, and load the wait counter with WAIT_STATES. Go to WAIT, or go directly to ACK if WAIT_STATES = 0.
  - WAIT: decrement the counter each cycle; go to ACK on the cycle the counter reaches 0.
  - ACK: ack = 1 for exactly one cycle. rdata is driven from the captured address; stores commit on the clock edge that ends ACK. Then return to IDLE.
  - Latency: req sampled on edge N gives ack high during cycle N+1+WAIT_STATES.
  - Requests are accepted only in IDLE. req still high in the first IDLE cycle after ack is treated as a new access.
  - Changes to addr, we or wdata after capture have no effect.
- Out-of-window address: same latency; ack = 1, err = 1, rdata = 0, no register changes.
- Timer:
  - While en = 1, TCOUNT increments every cycle and wraps from 16'hFFFF to 0.
  - When TCOUNT == TCMP while en = 1, the flag is set.
  - On a match with auto-reload = 1, TCOUNT loads 0.
  - On a match with auto-reload = 0, en clears and TCOUNT holds its value.
  - TCMP = 0 with auto-reload gives a match on every cycle.
- Simultaneous events:
  - A hardware flag set and a W1C in the same cycle: the set wins.
  - A CPU write to TCOUNT or CTRL in the same cycle as an increment or match: the CPU write wins.
- irq is registered: it follows flag & ie with one cycle of delay.
- Switch path: sw passes through a 2-flop synchroniser. A read returns the synchronised value at the ACK cycle.

Test Plan:
1. Reset released, WAIT_STATES = 2; load from 0xFF05 with sw = 8'hA5, stable for more than 3 cycles. Required: ack exactly 3 cycles after the req edge, rdata = 16'h00A5, err = 0.
2. Store 16'h003C to 0xFF04, then load from 0xFF04. Required: leds = 8'h3C after the store's ACK cycle; the read returns 16'h003C.
3. TCMP = 5, CTRL = 3'b111. Required: TCOUNT counts 0..5; the flag sets at the match; TCOUNT reloads to 0; irq rises one cycle after the flag. Then write 1 to STATUS. Required: flag and irq clear, unless a new match lands in the same cycle, in which case the flag stays 1.
4. CTRL = 3'b001, TCMP = 3. Required: the match sets the flag, en clears, and TCOUNT holds 3 from then on.
5. Load from 0x1234. Required: ack and err pulse together after 3 cycles, rdata = 0, and no register changes.
6. Pull Reset low during the WAIT state of a store to LEDS. Required: no ack; leds = 0. After release, a new access completes normally.

Source files
------------

// File: rtl/cr16_mmio_responder.sv
// cr16_mmio_responder
//   Target side of the CR16 load/store request/acknowledge handshake. Decodes
//   an 8-word window at BASE_ADDR and serves each access after WAIT_STATES
//   extra cycles. Behind the window sit a compare/match timer with interrupt,
//   an LED latch and a synchronised switch input.
//
// Ports
//   Clk    : system clock, rising edge
//   Reset  : asynchronous reset, active low
//   req    : access request, held by the CPU until ack
//   we     : 1 = store, 0 = load (sampled with req)
//   addr   : word address
//   wdata  : store data
//   rdata  : load data, non-zero only while ack is high
//   ack    : one-cycle completion strobe
//   err    : pulses with ack for addresses outside the window
//   irq    : registered timer interrupt (flag & CTRL.ie)
//   leds   : LED register
//   sw     : asynchronous switch inputs
//
// Register map (addr[2:0]): 0 CTRL {ie, auto_reload, en}, 1 STATUS flag (W1C),
//   2 TCOUNT, 3 TCMP, 4 LEDS, 5 SW (read-only), 6/7 read as zero.
module cr16_mmio_responder #(
  parameter logic [15:0] BASE_ADDR   = 16'hFF00,
  parameter int          WAIT_STATES = 2,
  parameter int          LED_W       = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             req,
  input  logic             we,
  input  logic [15:0]      addr,
  input  logic [15:0]      wdata,
  output logic [15:0]      rdata,
  output logic             ack,
  output logic             err,
  output logic             irq,
  output logic [LED_W-1:0] leds,
  input  logic [LED_W-1:0] sw
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);
  localparam logic       NO_WAIT   = (WAIT_STATES == 0);

  state_t            state_reg;
  logic [3:0]        wait_cnt_reg;
  logic [2:0]        offs_reg;
  logic [15:0]       wdata_reg;
  logic              we_reg;
  logic              hit_reg;
  logic              ack_reg;
  logic              err_reg;

  logic [2:0]        ctrl_reg, ctrl_next;
  logic              flag_reg, flag_next;
  logic [15:0]       tcount_reg, tcount_next;
  logic [15:0]       tcmp_reg, tcmp_next;
  logic [LED_W-1:0]  leds_reg, leds_next;
  logic [LED_W-1:0]  sw_meta_reg, sw_sync_reg;
  logic              irq_reg;

  logic              hit_now;
  logic              wr_en;
  logic              match;
  logic [15:0]       rd_mux;

  assign hit_now = (addr[15:3] == BASE_ADDR[15:3]);

  // Handshake FSM. ack/err are registered and are high exactly in ST_ACK.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_reg    <= ST_IDLE;
      wait_cnt_reg <= '0;
      offs_reg     <= '0;
      wdata_reg    <= '0;
      we_reg       <= 1'b0;
      hit_reg      <= 1'b0;
      ack_reg      <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          ack_reg <= 1'b0;
          err_reg <= 1'b0;
          if (req) begin
            offs_reg     <= addr[2:0];
            wdata_reg    <= wdata;
            we_reg       <= we;
            hit_reg      <= hit_now;
            wait_cnt_reg <= WAIT_INIT;
            if (NO_WAIT) begin
              state_reg <= ST_ACK;
              ack_reg   <= 1'b1;
              err_reg   <= ~hit_now;
            end else begin
              state_reg <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          // The counter is loaded with WAIT_STATES on capture; ACK follows
          // the cycle in which it has run down to zero.
          if (wait_cnt_reg == 4'd0) begin
            state_reg <= ST_ACK;
            ack_reg   <= 1'b1;
            err_reg   <= ~hit_reg;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 4'd1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          ack_reg   <= 1'b0;
          err_reg   <= 1'b0;
        end
      endcase
    end
  end

  // Stores commit on the edge that ends ACK.
  assign wr_en = (state_reg == ST_ACK) && we_reg && hit_reg;
  assign match = ctrl_reg[0] && (tcount_reg == tcmp_reg);

  always_comb begin
    ctrl_next   = ctrl_reg;
    flag_next   = flag_reg;
    tcount_next = tcount_reg;
    tcmp_next   = tcmp_reg;
    leds_next   = leds_reg;

    if (ctrl_reg[0]) begin
      if (match) begin
        if (ctrl_reg[1]) tcount_next = '0;
        else             ctrl_next[0] = 1'b0;
      end else begin
        tcount_next = tcount_reg + 16'd1;
      end
    end

    // CPU writes come after the timer update so they override it.
    if (wr_en) begin
      case (offs_reg)
        3'd0: ctrl_next   = wdata_reg[2:0];
        3'd1: if (wdata_reg[0]) flag_next = 1'b0;
        3'd2: tcount_next = wdata_reg;
        3'd3: tcmp_next   = wdata_reg;
        3'd4: leds_next   = wdata_reg[LED_W-1:0];
        default: ;
      endcase
    end

    // A hardware match beats a simultaneous W1C.
    if (match) flag_next = 1'b1;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ctrl_reg   <= '0;
      flag_reg   <= 1'b0;
      tcount_reg <= '0;
      tcmp_reg   <= '0;
      leds_reg   <= '0;
      irq_reg    <= 1'b0;
    end else begin
      ctrl_reg   <= ctrl_next;
      flag_reg   <= flag_next;
      tcount_reg <= tcount_next;
      tcmp_reg   <= tcmp_next;
      leds_reg   <= leds_next;
      irq_reg    <= flag_reg & ctrl_reg[2];
    end
  end

  // Two-flop synchroniser, one chain per switch bit.
  genvar gi;
  generate
    for (gi = 0; gi < LED_W; gi++) begin : g_sw_sync
      always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
          sw_meta_reg[gi] <= 1'b0;
          sw_sync_reg[gi] <= 1'b0;
        end else begin
          sw_meta_reg[gi] <= sw[gi];
          sw_sync_reg[gi] <= sw_meta_reg[gi];
        end
      end
    end
  endgenerate

  always_comb begin
    rd_mux = '0;
    case (offs_reg)
      3'd0: rd_mux = 16'(ctrl_reg);
      3'd1: rd_mux = 16'(flag_reg);
      3'd2: rd_mux = tcount_reg;
      3'd3: rd_mux = tcmp_reg;
      3'd4: rd_mux = 16'(leds_reg);
      3'd5: rd_mux = 16'(sw_sync_reg);
      default: rd_mux = '0;
    endcase
  end

  assign rdata = (ack_reg && hit_reg) ? rd_mux : 16'h0000;
  assign ack   = ack_reg;
  assign err   = err_reg;
  assign irq   = irq_reg;
  assign leds  = leds_reg;

endmodule
